ifetch_unit: RTL

//  Instruction-fetch sequencer directly downstream of the PC register.
//  - Latches the current PC, runs a req/ack transaction to instruction memory, and presents {inst, pc} to decode over valid/ready.
//  - Drives pc_ena to advance the PC register exactly once per accepted fetch.
//  - flush discards the in-flight or held instruction after a redirect.

---
 rtl/ifetch_pkg.sv | 25 ++
 rtl/ifetch_out_reg.sv | 32 +++
 rtl/ifetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Optional misalignment handling is enabled by IFETCH_ALIGN_CHK_EN (see ifetch_unit).
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } ifetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        misalign;
    } fetch_pkt_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_out_reg.sv
// Holding register for the {inst, pc, misalign} packet presented to decode.
module ifetch_out_reg
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  fetch_pkt_t din,
    output fetch_pkt_t dout
);

    fetch_pkt_t pkt_r;

    // Packet register: reset to the NOP/RESET_PC pair, otherwise load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_r.inst     <= NOP_INST;
            pkt_r.pc       <= RESET_PC;
            pkt_r.misalign <= 1'b0;
        end else if (load) begin
            pkt_r <= din;
        end else begin
            pkt_r <= pkt_r;
        end
    end

    assign dout = pkt_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: latches PC, runs req/ack to imem, presents {inst, pc} to decode.
// Define IFETCH_ALIGN_CHK_EN to turn misaligned PCs into NOP packets flagged out_misalign.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_ena,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_misalign
);

    ifetch_state_e state_r;
    ifetch_state_e next_state_s;
    logic [31:0]   addr_r;
    logic          imem_req_r;
    logic          out_valid_r;
    logic          addr_load_s;
    logic          enter_req_s;
    logic          out_load_s;
    logic          pc_ena_s;
    fetch_pkt_t    out_din_s;
    fetch_pkt_t    out_q_s;

    // Next-state, capture and pc_ena decode; every path into S_REQ goes through enter_req_s.
    always_comb begin
        next_state_s       = state_r;
        enter_req_s        = 1'b0;
        addr_load_s        = 1'b0;
        out_load_s         = 1'b0;
        pc_ena_s           = 1'b0;
        out_din_s.inst     = imem_rdata;
        out_din_s.pc       = addr_r;
        out_din_s.misalign = 1'b0;

        case (state_r)
            S_IDLE: begin
                enter_req_s = 1'b1;
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (flush) begin
                        enter_req_s = 1'b1;
                    end else begin
                        next_state_s = S_HOLD;
                        out_load_s   = 1'b1;
                        pc_ena_s     = 1'b1;
                    end
                end else if (flush) begin
                    next_state_s = S_DROP;
                end else begin
                    next_state_s = S_REQ;
                end
            end
            S_DROP: begin
                // The outstanding beat must still complete; its data is thrown away.
                if (imem_ack) begin
                    enter_req_s = 1'b1;
                end else begin
                    next_state_s = S_DROP;
                end
            end
            S_HOLD: begin
                if (flush || out_ready) begin
                    enter_req_s = 1'b1;
                end else begin
                    next_state_s = S_HOLD;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase

        if (enter_req_s) begin
            addr_load_s = 1'b1;
`ifdef IFETCH_ALIGN_CHK_EN
            if (is_misaligned(pc)) begin
                next_state_s       = S_HOLD;
                out_load_s         = 1'b1;
                out_din_s.inst     = NOP_INST;
                out_din_s.pc       = pc;
                out_din_s.misalign = 1'b1;
            end else begin
                next_state_s = S_REQ;
            end
`else
            next_state_s = S_REQ;
`endif
        end else begin
            addr_load_s = 1'b0;
        end
    end

    // State, fetch address and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            addr_r      <= 32'h0000_0000;
            imem_req_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            addr_r      <= addr_load_s ? pc : addr_r;
            imem_req_r  <= (next_state_s == S_REQ) || (next_state_s == S_DROP);
            out_valid_r <= (next_state_s == S_HOLD);
        end
    end

    ifetch_out_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_out_reg (
        .clk  (clk),
        .rst  (rst),
        .load (out_load_s),
        .din  (out_din_s),
        .dout (out_q_s)
    );

    assign pc_ena       = pc_ena_s;
    assign imem_req     = imem_req_r;
`ifdef IFETCH_ALIGN_CHK_EN
    assign imem_addr    = addr_r;
`else
    assign imem_addr    = addr_r & 32'hFFFF_FFFC;
`endif
    assign out_valid    = out_valid_r;
    assign out_inst     = out_q_s.inst;
    assign out_pc       = out_q_s.pc;
    // Only the misaligned path ever loads a 1, so this stays 0 in the default build.
    assign out_misalign = out_q_s.misalign;

endmodule
